// File: rtl/vga_stream_pkg.sv
// vga_stream_pkg
// Shared constants for the VGA stream: bit positions of the fields inside the
// 23-bit sync/coordinate stream, the width of the RGB-extended stream used by
// the drawing stages, and the default 640x480@60 timing.
package vga_stream_pkg;

  // Stream field positions: {active, vsync, hsync, y[9:0], x[9:0]}
  localparam int STR_X_LSB = 0;
  localparam int STR_Y_LSB = 10;
  localparam int STR_HS    = 20;
  localparam int STR_VS    = 21;
  localparam int STR_ACT   = 22;
  localparam int STR_W     = 23;

  // Width of the stream once drawing stages append RGB
  localparam int STR_RGB_W = 26;

  // Default 640x480 timing
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

endpackage

// File: rtl/vga_stream_sync_axis_counter.sv
// sync_axis_counter
// One timing axis (horizontal or vertical). Counts 0..TOTAL-1 on enabled
// cycles and decodes the active and sync regions from the current count.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : advance the count this cycle
//   count      : current position on the axis
//   active     : count lies in the visible region
//   sync       : sync level for the current count (POL when asserted)
//   wrap       : count is at TOTAL-1 and advances this cycle
module sync_axis_counter #(
  parameter int   ACTIVE = 640,
  parameter int   FRONT  = 16,
  parameter int   SYNC   = 96,
  parameter int   BACK   = 48,
  parameter logic POL    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  output logic [9:0] count,
  output logic       active,
  output logic       sync,
  output logic       wrap
);

  localparam int         TOTAL      = ACTIVE + FRONT + SYNC + BACK;
  localparam logic [9:0] LAST       = 10'(TOTAL - 1);
  // 11-bit bounds so an axis totalling exactly 1024 still compares correctly
  localparam logic [10:0] ACT_END   = 11'(ACTIVE);
  localparam logic [10:0] SYNC_BEG  = 11'(ACTIVE + FRONT);
  localparam logic [10:0] SYNC_END  = 11'(ACTIVE + FRONT + SYNC);

  logic [10:0] count_x;

  assign count_x = {1'b0, count};
  assign active  = (count_x < ACT_END);
  assign sync    = ((count_x >= SYNC_BEG) && (count_x < SYNC_END)) ? POL : ~POL;
  assign wrap    = ena && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (ena) begin
      count <= (count == LAST) ? '0 : count + 10'd1;
    end
  end

endmodule

// File: rtl/vga_stream_gen.sv
// vga_stream_gen
// Source of the VGA stream: horizontal/vertical timing counters feed one
// output register stage, so strVGA describes the counter state of the
// previous enabled cycle.
// Ports:
//   px_clk    : pixel clock
//   reset     : asynchronous active-low reset
//   ena       : count enable; low freezes counters, strVGA and frame_cnt
//   strVGA    : {active, vsync, hsync, y[9:0], x[9:0]}
//   endframe  : one-cycle pulse while strVGA carries the last pixel of a frame
//   frame_cnt : completed-frame counter, wraps mod 256
module vga_stream_gen
  import vga_stream_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FRONT  = DEF_H_FRONT,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BACK   = DEF_H_BACK,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FRONT  = DEF_V_FRONT,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BACK   = DEF_V_BACK,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic             px_clk,
  input  logic             reset,
  input  logic             ena,
  output logic [STR_W-1:0] strVGA,
  output logic             endframe,
  output logic [7:0]       frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Counters are 10 bits wide; larger timings cannot be represented
  if (H_TOTAL > 1024) begin : g_bad_h_total
    $error("vga_stream_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_bad_v_total
    $error("vga_stream_gen: V_TOTAL exceeds 1024");
  end

  localparam logic [STR_W-1:0] STR_RST =
    {1'b0, ~VS_POL, ~HS_POL, 20'd0};

  logic [9:0]       hc_p0, vc_p0;
  logic             h_act_p0, h_sync_p0, h_wrap_p0;
  logic             v_act_p0, v_sync_p0, v_wrap_p0;
  logic [STR_W-1:0] str_p0;

  sync_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK),
    .POL    (HS_POL)
  ) u_h_axis (
    .clk    (px_clk),
    .rst_n  (reset),
    .ena    (ena),
    .count  (hc_p0),
    .active (h_act_p0),
    .sync   (h_sync_p0),
    .wrap   (h_wrap_p0)
  );

  // The vertical axis steps once per line, when the horizontal axis wraps;
  // its wrap therefore marks the last pixel of the frame.
  sync_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK),
    .POL    (VS_POL)
  ) u_v_axis (
    .clk    (px_clk),
    .rst_n  (reset),
    .ena    (h_wrap_p0),
    .count  (vc_p0),
    .active (v_act_p0),
    .sync   (v_sync_p0),
    .wrap   (v_wrap_p0)
  );

  always_comb begin
    str_p0                       = '0;
    str_p0[STR_ACT]              = h_act_p0 && v_act_p0;
    str_p0[STR_VS]               = v_sync_p0;
    str_p0[STR_HS]               = h_sync_p0;
    str_p0[STR_Y_LSB +: 10]      = vc_p0;
    str_p0[STR_X_LSB +: 10]      = hc_p0;
  end

  // ---- stage p0 -> p1: registered outputs ----
  always_ff @(posedge px_clk or negedge reset) begin
    if (!reset) begin
      strVGA    <= STR_RST;
      endframe  <= 1'b0;
      frame_cnt <= 8'd0;
    end else if (ena) begin
      strVGA   <= str_p0;
      endframe <= v_wrap_p0;
      if (v_wrap_p0) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end else begin
      // Freeze everything but never stretch an end-of-frame pulse
      endframe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_stream_gen.sv
module tb_vga_stream_gen;

  // Reduced timing so many full frames fit in a short run
  localparam int   HA = 8, HF = 2, HSW = 3, HB = 2;
  localparam int   VA = 5, VF = 1, VSW = 2, VB = 2;
  localparam logic HS_POL = 1'b0;
  localparam logic VS_POL = 1'b1;
  localparam int   HT = HA + HF + HSW + HB;
  localparam int   VT = VA + VF + VSW + VB;
  localparam int   FT = HT * VT;
  localparam logic [22:0] RST_STR = {1'b0, ~VS_POL, ~HS_POL, 20'd0};

  logic        px_clk = 1'b0;
  logic        reset;
  logic        ena;
  logic [22:0] strVGA;
  logic        endframe;
  logic [7:0]  frame_cnt;

  vga_stream_gen #(
    .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HSW), .H_BACK (HB),
    .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VSW), .V_BACK (VB),
    .HS_POL   (HS_POL), .VS_POL (VS_POL)
  ) dut (
    .px_clk    (px_clk),
    .reset     (reset),
    .ena       (ena),
    .strVGA    (strVGA),
    .endframe  (endframe),
    .frame_cnt (frame_cnt)
  );

  always #5 px_clk = ~px_clk;

  int          tests = 0;
  int          fails = 0;
  int          p;          // linear index of the next pixel to be emitted
  int          ef_seen;
  logic [22:0] exp_str;
  logic        exp_ef;
  logic [7:0]  exp_fc;
  logic [7:0]  fc0;

  // Expected stream word for linear pixel index q, straight from the field rules
  function automatic logic [22:0] pix(input int q);
    int   x, y;
    logic act, hs, vs;
    x   = q % HT;
    y   = q / HT;
    act = (x < HA) && (y < VA);
    hs  = (x >= HA + HF && x < HA + HF + HSW) ? HS_POL : ~HS_POL;
    vs  = (y >= VA + VF && y < VA + VF + VSW) ? VS_POL : ~VS_POL;
    return {act, vs, hs, 10'(y), 10'(x)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    p       = 0;
    exp_str = RST_STR;
    exp_ef  = 1'b0;
    exp_fc  = 8'd0;
  endtask

  // Drive ena for one clock, advance the model, check all outputs 1 time unit later
  task automatic step(input logic e);
    ena = e;
    @(posedge px_clk);
    if (!reset) begin
      model_reset();
    end else if (e) begin
      exp_str = pix(p);
      exp_ef  = (p == FT - 1);
      if (exp_ef) exp_fc = exp_fc + 8'd1;
      p = (p + 1) % FT;
    end else begin
      exp_ef = 1'b0;
    end
    #1;
    if (endframe === 1'b1) ef_seen++;
    check("strVGA", 32'(strVGA), 32'(exp_str));
    check("endframe", 32'(endframe), 32'(exp_ef));
    check("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < FT && p != target; i++) step(1'b1);
  endtask

  initial begin
    ef_seen = 0;
    reset   = 1'b0;
    ena     = 1'b1;
    model_reset();

    // Held in reset: outputs at reset values
    repeat (3) step(1'b1);

    // Release away from the clock edge; first edge emits (0,0) active
    #3 reset = 1'b1;
    step(1'b1);
    check("first_active", 32'(strVGA[22]), 32'd1);

    // Two full frames continuously enabled
    repeat (2 * FT) step(1'b1);

    // Freeze mid-frame, then resume with no skipped/duplicated pixel
    run_to(2 * HT + 4);
    repeat (5) step(1'b0);
    step(1'b1);

    // ena low while counters sit on the last pixel: no wrap, no pulse
    run_to(FT - 1);
    repeat (3) step(1'b0);
    step(1'b1);
    check("late_endframe", 32'(endframe), 32'd1);

    // Randomized enable pattern
    for (int i = 0; i < 600; i++) step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);

    // 256 frames: exactly 256 pulses and frame_cnt returns to its start value
    run_to(0);
    fc0     = exp_fc;
    ef_seen = 0;
    repeat (256 * FT) step(1'b1);
    check("ef_count", 32'(ef_seen), 32'd256);
    check("fc_wrap", 32'(frame_cnt), 32'(fc0));

    // Asynchronous reset mid-frame: outputs change before the next edge
    run_to(6 * HT + 4);
    #3 reset = 1'b0;
    #1;
    check("async_str", 32'(strVGA), 32'(RST_STR));
    check("async_ef", 32'(endframe), 32'd0);
    check("async_fc", 32'(frame_cnt), 32'd0);
    model_reset();
    repeat (2) step(1'b1);
    #3 reset = 1'b1;
    repeat (HT + 3) step(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
